// File: rtl/frame_stream_loader_pkg.sv
// Shared types and default geometry for the frame stream loader and its scan-index counter.
package frame_stream_loader_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int FRAME_BEATS = ROWS * COLS;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef elem_t frame_t [ROWS-1:0][COLS-1:0];

  // Index width that stays at least one bit for degenerate single-entry dimensions.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Raster beat counter with terminal-count flag and row/col decode.
// Also used by the max-search stage for its scan indexing.
module frame_beat_counter #(
  parameter  int ROWS  = 8,
  parameter  int COLS  = 8,
  localparam int ROW_W = frame_stream_loader_pkg::idx_width(ROWS),
  localparam int COL_W = frame_stream_loader_pkg::idx_width(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             terminal
);
  import frame_stream_loader_pkg::*;

  localparam int BEATS = ROWS * COLS;
  localparam int CNT_W = idx_width(BEATS);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign row      = ROW_W'(int'(count) / COLS);
  assign col      = COL_W'(int'(count) % COLS);
  assign terminal = (count == CNT_W'(BEATS - 1));

endmodule

// File: rtl/frame_stream_loader.sv
// Assembles a raster-order valid/ready element stream into a ROWS x COLS frame and
// presents it to the max-search stage. Define FRAME_LOADER_PINGPONG_EN for the
// double-buffered build; the default build uses a single frame buffer.
module frame_stream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] frame_out [ROWS-1:0][COLS-1:0],
  output logic                  frame_valid,
  input  logic                  done_in,
  output logic                  frame_err,
  output logic                  busy
);
  import frame_stream_loader_pkg::*;

  localparam int ROW_W = idx_width(ROWS);
  localparam int COL_W = idx_width(COLS);

  state_t           state;
  logic             accept;
  logic             terminal;
  logic             wr_last;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  assign accept  = in_valid && in_ready;
  assign wr_last = accept && terminal;

  // A last-marked beat or the final beat position both close out the current fill.
  frame_beat_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept && (terminal || in_last)),
    .inc      (accept),
    .row      (row),
    .col      (col),
    .terminal (terminal)
  );

  // Early last and missing last are the two ways in_last can disagree with the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && (terminal != in_last);
    end
  end

`ifdef FRAME_LOADER_PINGPONG_EN

  logic                  rd_sel;
  logic                  wr_full;
  logic [DATA_WIDTH-1:0] bufs [2][ROWS-1:0][COLS-1:0];

  // NOTE: the frame buffers are reset because a cleared frame_out is part of the
  // reset state; storage that is never observed before being written would not need it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            bufs[b][r][c] <= '0;
    end else if (accept) begin
      bufs[~rd_sel][row][col] <= in_data;
    end
  end

  // NOTE: every element is assigned on every evaluation, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        frame_out[r][c] = bufs[rd_sel][r][c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      in_ready    <= 1'b1;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      rd_sel      <= 1'b0;
      wr_full     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        FILL: begin
          if (wr_last) begin
            rd_sel      <= ~rd_sel;
            frame_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          state <= WAIT_DONE;
          if (wr_last) begin
            wr_full  <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        WAIT_DONE: begin
          // A final beat landing with done_in counts as a full write buffer.
          if (done_in && (wr_full || wr_last)) begin
            rd_sel      <= ~rd_sel;
            wr_full     <= 1'b0;
            in_ready    <= 1'b1;
            frame_valid <= 1'b1;
            state       <= PRESENT;
          end else if (done_in) begin
            busy  <= 1'b0;
            state <= FILL;
          end else if (wr_last) begin
            wr_full  <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          wr_full  <= 1'b0;
          state    <= FILL;
        end
      endcase
    end
  end

`else

  logic [DATA_WIDTH-1:0] frame_q [ROWS-1:0][COLS-1:0];

  // NOTE: the frame store is reset because a cleared frame_out is part of the
  // reset state; storage that is never observed before being written would not need it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          frame_q[r][c] <= '0;
    end else if (accept) begin
      frame_q[row][col] <= in_data;
    end
  end

  // NOTE: every element is assigned on every evaluation, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        frame_out[r][c] = frame_q[r][c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      in_ready    <= 1'b1;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        FILL: begin
          if (wr_last) begin
            in_ready    <= 1'b0;
            frame_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          // The consumer cannot finish within the presentation cycle.
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_in) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= FILL;
          end
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= FILL;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_frame_stream_loader.sv
// Directed bench for frame_stream_loader: a frame-scenario table plus hand-written
// sequences for early last, mid-frame reset and the double-buffered handoff.
module tb_frame_stream_loader;
  import frame_stream_loader_pkg::*;

  localparam int NB = FRAME_BEATS;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [DATA_WIDTH-1:0] frame_out [ROWS-1:0][COLS-1:0];
  logic                  frame_valid;
  logic                  done_in;
  logic                  frame_err;
  logic                  busy;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_seen  = 0;

  typedef struct {
    string name;
    int    base;
    int    step;
    int    last_idx;
    int    exp_err;
    int    hold;
    bit    done_in_present;
  } vec_t;

  frame_stream_loader #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROWS       (ROWS),
    .COLS       (COLS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .done_in     (done_in),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid) fv_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_frame(input string name, input int base, input int step);
    int bad = 0;
    for (int k = 0; k < NB; k++)
      if (frame_out[k / COLS][k % COLS] !== DATA_WIDTH'(base + step * k)) bad++;
    check({name, " mismatched elements"}, bad, 0);
  endtask

  // Presents one beat at a negedge and returns at the negedge after it was accepted.
  task automatic send_beat(input logic [DATA_WIDTH-1:0] d, input logic l);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready wait: got 0 after %0d cycles, expected 1", waited);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int step, input int last_idx, input int nbeats);
    for (int k = 0; k < nbeats; k++)
      send_beat(DATA_WIDTH'(base + step * k), k == last_idx);
  endtask

  // Caller must already be in WAIT_DONE.
  task automatic release_frame(input string name);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    check({name, " in_ready after done"}, in_ready, 1);
    check({name, " busy after done"}, busy, 0);
  endtask

  initial begin
    vec_t vecs [3];
    int   fv0;
    int   bad;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    done_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset frame_valid", frame_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset busy", busy, 0);
    check_frame("reset frame_out", 0, 0);
    rst = 1'b0;

`ifndef FRAME_LOADER_PINGPONG_EN
    vecs[0] = '{"ramp",     0,     1, 63, 0, 20, 1'b0};
    vecs[1] = '{"const_a5", 'hA5,  0, 63, 0, 0,  1'b0};
    vecs[2] = '{"no_last",  7,     3, -1, 1, 0,  1'b1};

    for (int i = 0; i < 3; i++) begin
      send_frame(vecs[i].base, vecs[i].step, vecs[i].last_idx, NB);
      check({vecs[i].name, " frame_valid"}, frame_valid, 1);
      check({vecs[i].name, " frame_err"}, frame_err, vecs[i].exp_err);
      check({vecs[i].name, " in_ready in present"}, in_ready, 0);
      check_frame(vecs[i].name, vecs[i].base, vecs[i].step);
      if (i == 0) begin
        check("ramp frame_out[7][7]", frame_out[7][7], 63);
        check("ramp frame_out[2][5]", frame_out[2][5], 21);
      end
      done_in = vecs[i].done_in_present;
      @(negedge clk);
      done_in = 1'b0;
      check({vecs[i].name, " frame_valid one cycle"}, frame_valid, 0);
      check({vecs[i].name, " busy waiting"}, busy, 1);
      check({vecs[i].name, " in_ready waiting"}, in_ready, 0);
      if (vecs[i].hold > 0) begin
        bad      = 0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b0;
        for (int c = 0; c < vecs[i].hold; c++) begin
          @(negedge clk);
          if (in_ready || !busy) bad++;
        end
        in_valid = 1'b0;
        check({vecs[i].name, " cycles ready while held"}, bad, 0);
        check_frame({vecs[i].name, " held"}, vecs[i].base, vecs[i].step);
      end
      release_frame(vecs[i].name);
    end
`endif

    // Early last on beat 10 drops the partial frame.
    fv0 = fv_seen;
    send_frame(200, 1, 10, 11);
    check("early_last frame_err", frame_err, 1);
    check("early_last frame_valid", frame_valid, 0);
    check("early_last in_ready", in_ready, 1);
    send_frame(100, 1, 63, NB);
    check("after_err frame_valid", frame_valid, 1);
    check("after_err frame_err", frame_err, 0);
    check("after_err frame_out[0][0]", frame_out[0][0], 100);
    check_frame("after_err", 100, 1);
    check("early_last extra valid pulses", fv_seen - fv0, 0);
    @(negedge clk);
    release_frame("after_err");

    // Asynchronous reset after 30 beats of a frame.
    send_frame(50, 1, -1, 30);
    #2 rst = 1'b1;
    #1;
    check("midrst in_ready", in_ready, 1);
    check("midrst busy", busy, 0);
    check("midrst frame_valid", frame_valid, 0);
    check("midrst frame_out[0][0]", frame_out[0][0], 0);
    check("midrst frame_out[3][5]", frame_out[3][5], 0);
    @(negedge clk);
    rst = 1'b0;
    fv0 = fv_seen;
    send_frame(9, 5, 63, NB);
    check("post_reset frame_valid", frame_valid, 1);
    check("post_reset valid pulses before", fv_seen - fv0, 0);
    check_frame("post_reset", 9, 5);
    @(negedge clk);
    release_frame("post_reset");

`ifdef FRAME_LOADER_PINGPONG_EN
    send_frame(1, 1, 63, NB);
    check("pp_a frame_valid", frame_valid, 1);
    check("pp_a in_ready", in_ready, 1);
    check_frame("pp_a", 1, 1);
    // Frame B fills while A is held; done_in coincides with B's final beat.
    send_frame(64, 2, -1, NB - 1);
    check("pp_b filling frame_valid", frame_valid, 0);
    check_frame("pp_a held", 1, 1);
    done_in = 1'b1;
    send_beat(DATA_WIDTH'(64 + 2 * (NB - 1)), 1'b1);
    done_in = 1'b0;
    check("pp_b frame_valid", frame_valid, 1);
    check("pp_b in_ready", in_ready, 1);
    check("pp_b busy", busy, 1);
    check_frame("pp_b", 64, 2);
    // Frame C completes the write buffer while B is still held.
    send_frame(30, 7, 63, NB);
    check("pp_c full in_ready", in_ready, 0);
    check("pp_c full frame_valid", frame_valid, 0);
    check_frame("pp_b held", 64, 2);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    check("pp_c frame_valid", frame_valid, 1);
    check("pp_c in_ready", in_ready, 1);
    check_frame("pp_c", 30, 7);
    @(negedge clk);
    release_frame("pp_c");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
